// File: rtl/button_event.sv
// Per-channel press/release pulse and long-hold detector for debounced inputs.
// Optional auto-repeat of press while held: define BUTTON_EVENT_AUTO_REPEAT_EN.
// The release pulse output is named rel because "release" is a reserved word.
module button_event #(
  parameter int N            = 1,
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_TICKS = 100,
  parameter int CW           = 16
) (
  input  logic           clk,
  input  logic           clr,
  input  logic [N-1:0]   in,
  input  logic           tick,
  output logic [N-1:0]   press,
  output logic [N-1:0]   rel,
  output logic [N-1:0]   held,
  output logic [2*N-1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TICKS - 1);
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_TICKS - 1);
`endif

  for (genvar i = 0; i < N; i++) begin : g_ch
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          held_q, held_d;

    // Handshake-free: in[i] and tick are plain levels sampled every clk edge;
    // press/rel are one-cycle strobes, held is a level, all registered.
    always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        held_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        held_q  <= held_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          // A tick coinciding with the press edge is deliberately not counted.
          if (in[i]) begin
            state_d = PRESSED;
            press_d = 1'b1;
          end
        end
        PRESSED: begin
          if (!in[i]) begin
            state_d = IDLE;
            rel_d   = 1'b1;
            cnt_d   = '0;
          end else if (tick) begin
            if (cnt_q == HOLD_LAST) begin
              state_d = HELD;
              cnt_d   = '0;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
              press_d = 1'b1;
`endif
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        HELD: begin
          if (!in[i]) begin
            state_d = IDLE;
            rel_d   = 1'b1;
            cnt_d   = '0;
          end else begin
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
            if (tick) begin
              if (cnt_q == REP_LAST) begin
                press_d = 1'b1;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
`else
            cnt_d = '0;
`endif
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
      held_d = (state_d == HELD);
    end

    assign press[i]            = press_q;
    assign rel[i]              = rel_q;
    assign held[i]             = held_q;
    assign state_dbg[2*i +: 2] = state_q;
  end

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event: N=2, HOLD_TICKS=4, REPEAT_TICKS=2.
// Expectations follow the build: auto-repeat when BUTTON_EVENT_AUTO_REPEAT_EN is defined.
module tb_button_event;
  localparam int N = 2;

`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic           clk;
  logic           clr;
  logic [N-1:0]   in;
  logic           tick;
  logic [N-1:0]   press;
  logic [N-1:0]   rel;
  logic [N-1:0]   held;
  logic [2*N-1:0] state_dbg;

  int checks;
  int failures;

  button_event #(
    .N(N), .HOLD_TICKS(4), .REPEAT_TICKS(2), .CW(16)
  ) dut (
    .clk(clk), .clr(clr), .in(in), .tick(tick),
    .press(press), .rel(rel), .held(held), .state_dbg(state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] p, input logic [1:0] r,
                     input logic [1:0] h);
    checks++;
    assert ({press, rel, held} === {p, r, h}) else begin
      failures++;
      $error("FAIL %s observed press=%b rel=%b held=%b expected press=%b rel=%b held=%b",
             tag, press, rel, held, p, r, h);
    end
  endtask

  initial begin
    logic [1:0] ep;
    checks   = 0;
    failures = 0;
    clr  = 1'b1;
    in   = 2'b00;
    tick = 1'b1;

    // reset state
    step();
    step();
    chk("reset_outputs", 2'b00, 2'b00, 2'b00);
    checks++;
    assert (state_dbg === 4'b0000) else begin
      failures++;
      $error("FAIL reset_state observed=%b expected=%b", state_dbg, 4'b0000);
    end
    clr = 1'b0;
    step();
    chk("idle_after_reset", 2'b00, 2'b00, 2'b00);

    // reset mid-hold
    in = 2'b01;
    step();
    chk("rst_hold_press", 2'b01, 2'b00, 2'b00);
    for (int j = 1; j < 10; j++) begin
      step();
      ep = (REP && (j == 4 || j == 6 || j == 8)) ? 2'b01 : 2'b00;
      chk($sformatf("rst_hold_%0d", j), ep, 2'b00, (j >= 4) ? 2'b01 : 2'b00);
    end
    clr = 1'b1;
    #1;
    chk("async_clr_immediate", 2'b00, 2'b00, 2'b00);
    step();
    chk("clr_held_high", 2'b00, 2'b00, 2'b00);
    clr = 1'b0;
    step();
    chk("press_after_clr", 2'b01, 2'b00, 2'b00);
    in = 2'b00;
    step();
    chk("rel_after_clr_press", 2'b00, 2'b01, 2'b00);
    step();
    chk("idle_again", 2'b00, 2'b00, 2'b00);

    // short press
    in = 2'b01;
    step();
    chk("short_press", 2'b01, 2'b00, 2'b00);
    in = 2'b00;
    step();
    chk("short_release", 2'b00, 2'b01, 2'b00);
    step();
    chk("short_quiet", 2'b00, 2'b00, 2'b00);

    // long hold: press, held at +4, repeats at +6/+8/+10 when enabled
    in = 2'b01;
    for (int j = 0; j < 12; j++) begin
      step();
      ep = (j == 0 || (REP && (j == 4 || j == 6 || j == 8 || j == 10))) ? 2'b01 : 2'b00;
      chk($sformatf("long_hold_%0d", j), ep, 2'b00, (j >= 4) ? 2'b01 : 2'b00);
    end
    in = 2'b00;
    step();
    chk("long_release", 2'b00, 2'b01, 2'b00);
    step();
    chk("long_quiet", 2'b00, 2'b00, 2'b00);

    // tick gating: ticks at j%3==0; the tick on the press edge is not counted
    in = 2'b10;
    for (int j = 0; j <= 12; j++) begin
      tick = (j % 3 == 0);
      step();
      ep = (j == 0 || (REP && j == 12)) ? 2'b10 : 2'b00;
      chk($sformatf("gate_hold_%0d", j), ep, 2'b00, (j == 12) ? 2'b10 : 2'b00);
    end
    tick = 1'b0;
    in   = 2'b00;
    step();
    chk("gate_release", 2'b00, 2'b10, 2'b00);

    // release lands on what would be the 4th counted tick
    in = 2'b10;
    for (int j = 0; j < 12; j++) begin
      tick = (j % 3 == 0);
      step();
      chk($sformatf("gate_race_%0d", j), (j == 0) ? 2'b10 : 2'b00, 2'b00, 2'b00);
    end
    tick = 1'b1;
    in   = 2'b00;
    step();
    chk("gate_race_release", 2'b00, 2'b10, 2'b00);
    step();
    chk("gate_race_quiet", 2'b00, 2'b00, 2'b00);

    // simultaneous channels
    in = 2'b11;
    step();
    chk("sim_press", 2'b11, 2'b00, 2'b00);
    step();
    chk("sim_hold1", 2'b00, 2'b00, 2'b00);
    in = 2'b01;
    step();
    chk("sim_rel1", 2'b00, 2'b10, 2'b00);
    step();
    chk("sim_cnt3", 2'b00, 2'b00, 2'b00);
    step();
    chk("sim_held0", REP ? 2'b01 : 2'b00, 2'b00, 2'b01);
    step();
    chk("sim_held0_stay", 2'b00, 2'b00, 2'b01);
    in = 2'b00;
    step();
    chk("sim_rel0", 2'b00, 2'b01, 2'b00);
    step();
    chk("sim_quiet", 2'b00, 2'b00, 2'b00);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
